// File: rtl/audio_sample_player_pkg.sv
// Shared audio-sample descriptors: sample indices, count, and start/length lookup.
// Also holds the player FSM state type.
package audio_sample_player_pkg;

  localparam int unsigned sampleBits   = 4;
  localparam int unsigned Sample_count = 6;

  localparam logic [sampleBits-1:0] Sample_BEEP  = 4'd0;
  localparam logic [sampleBits-1:0] Sample_JUMP  = 4'd1;
  localparam logic [sampleBits-1:0] Sample_COIN  = 4'd2;
  localparam logic [sampleBits-1:0] Sample_HIT   = 4'd3;
  localparam logic [sampleBits-1:0] Sample_EMPTY = 4'd4;
  localparam logic [sampleBits-1:0] Sample_OVER  = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    PLAY
  } player_state_t;

  function automatic logic [15:0] sampleStart(input logic [sampleBits-1:0] idx);
    case (idx)
      Sample_BEEP:  sampleStart = 16'h0000;
      Sample_JUMP:  sampleStart = 16'h0040;
      Sample_COIN:  sampleStart = 16'h0100;
      Sample_HIT:   sampleStart = 16'h0200;
      Sample_EMPTY: sampleStart = 16'h0300;
      Sample_OVER:  sampleStart = 16'h3F00;
      default:      sampleStart = 16'h0000;
    endcase
  endfunction

  // Indices at or beyond Sample_count report length 0, which the player ignores.
  function automatic logic [15:0] sampleLength(input logic [sampleBits-1:0] idx);
    case (idx)
      Sample_BEEP:  sampleLength = 16'd2;
      Sample_JUMP:  sampleLength = 16'd100;
      Sample_COIN:  sampleLength = 16'd3;
      Sample_HIT:   sampleLength = 16'd4;
      Sample_EMPTY: sampleLength = 16'd0;
      Sample_OVER:  sampleLength = 16'd6;
      default:      sampleLength = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/audio_sample_player_counter.sv
// Generic wrapping counter: counts 0..COUNTER_MAX while enabled, TRIG_OUT flags the last count.
module GenericCounter #(
  parameter int unsigned COUNTER_WIDTH = 4,
  parameter int unsigned COUNTER_MAX   = 9
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE_IN,
  output logic TRIG_OUT
);

  localparam logic [COUNTER_WIDTH-1:0] MAX_C = COUNTER_WIDTH'(COUNTER_MAX);

  logic [COUNTER_WIDTH-1:0] count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (ENABLE_IN) begin
      if (count == MAX_C) count <= '0;
      else                count <= count + 1'b1;
    end
  end

  assign TRIG_OUT = ENABLE_IN && (count == MAX_C);

endmodule

// File: rtl/audio_sample_player.sv
// Audio trigger consumer: streams 8-bit samples from the sample ROM at a fixed rate
// and drives a PWM audio pin plus the current sample level.
module audio_sample_player
  import audio_sample_player_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS = 4,
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned CLK_DIV     = 3125,
  parameter logic [7:0]  SILENCE     = 8'h80
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [SAMPLE_BITS-1:0] AUDIO_SELECT,
  input  logic                   AUDIO_TRIGGER,
  output logic [ADDR_WIDTH-1:0]  ROM_ADDR,
  input  logic [7:0]             ROM_DATA,
  output logic [7:0]             SAMPLE_OUT,
  output logic                   PWM_OUT,
  output logic                   PLAYING
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  player_state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [7:0]              sample_nxt;
  logic [ADDR_WIDTH-1:0]   remaining, remaining_nxt;
  logic [7:0]              pwm_cnt;

  logic [ADDR_WIDTH-1:0]   start_w;
  logic [ADDR_WIDTH:0]     len_w;
  logic                    accept;
  logic                    tick;
  logic                    div_reset;

  assign start_w = ADDR_WIDTH'(sampleStart(AUDIO_SELECT));
  assign len_w   = (ADDR_WIDTH + 1)'(sampleLength(AUDIO_SELECT));
  assign accept  = AUDIO_TRIGGER && (32'(AUDIO_SELECT) < Sample_count) && (len_w != '0);

  assign div_reset = RESET || accept || (state == PRIME);

  GenericCounter #(
    .COUNTER_WIDTH (DIV_W),
    .COUNTER_MAX   (CLK_DIV - 1)
  ) u_rate_div (
    .CLK       (CLK),
    .RESET     (div_reset),
    .ENABLE_IN (state == PLAY),
    .TRIG_OUT  (tick)
  );

  // remaining is loaded with length-1 at trigger accept rather than in PRIME;
  // nothing reads it before PLAY, so the visible behaviour is unchanged.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = ROM_ADDR;
    sample_nxt    = SAMPLE_OUT;
    remaining_nxt = remaining;
    if (accept) begin
      state_nxt     = PRIME;
      addr_nxt      = start_w;
      remaining_nxt = ADDR_WIDTH'(len_w - 1'b1);
    end else begin
      case (state)
        PRIME: begin
          state_nxt  = PLAY;
          sample_nxt = ROM_DATA;
          addr_nxt   = ROM_ADDR + 1'b1;
        end
        PLAY: begin
          if (tick) begin
            if (remaining != '0) begin
              sample_nxt    = ROM_DATA;
              addr_nxt      = ROM_ADDR + 1'b1;
              remaining_nxt = remaining - 1'b1;
            end else begin
              sample_nxt = SILENCE;
              state_nxt  = IDLE;
            end
          end
        end
        default: sample_nxt = SILENCE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      ROM_ADDR   <= '0;
      SAMPLE_OUT <= SILENCE;
      remaining  <= '0;
      pwm_cnt    <= '0;
      PWM_OUT    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ROM_ADDR   <= addr_nxt;
      SAMPLE_OUT <= sample_nxt;
      remaining  <= remaining_nxt;
      pwm_cnt    <= pwm_cnt + 1'b1;
      PWM_OUT    <= (pwm_cnt < SAMPLE_OUT);
    end
  end

  assign PLAYING = (state != IDLE);

  // Descriptors must not straddle the ROM address wrap.
  a_no_wrap: assert property (@(posedge CLK) disable iff (RESET)
    accept |-> ((int'(start_w) + int'(len_w)) <= (1 << ADDR_WIDTH)));

endmodule

// File: tb/tb_audio_sample_player.sv
// Randomized self-checking bench for audio_sample_player against a timeline-based model.
module tb_audio_sample_player;

  localparam int DIV = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  AUDIO_SELECT = '0;
  logic        AUDIO_TRIGGER = 1'b0;
  logic [13:0] ROM_ADDR;
  logic [7:0]  ROM_DATA;
  logic [7:0]  SAMPLE_OUT;
  logic        PWM_OUT;
  logic        PLAYING;

  logic [7:0]  mem [0:16383];

  assign ROM_DATA = mem[ROM_ADDR];

  audio_sample_player #(.CLK_DIV(DIV)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .AUDIO_SELECT  (AUDIO_SELECT),
    .AUDIO_TRIGGER (AUDIO_TRIGGER),
    .ROM_ADDR      (ROM_ADDR),
    .ROM_DATA      (ROM_DATA),
    .SAMPLE_OUT    (SAMPLE_OUT),
    .PWM_OUT       (PWM_OUT),
    .PLAYING       (PLAYING)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int n = 0;

  // reference model: one active playback described by trigger cycle, start and length
  bit          rst_pending = 1'b1;
  bit          active = 1'b0;
  int          m_t, m_start, m_len;
  logic [7:0]  e_sample = 8'h80;
  logic [13:0] e_addr = '0;
  bit          e_play = 1'b0;
  logic [7:0]  e_pc = '0;
  bit          e_pwm = 1'b0;

  function automatic int ref_start(input int i);
    case (i)
      0: return 'h000;  1: return 'h040;  2: return 'h100;
      3: return 'h200;  4: return 'h300;  5: return 'h3F00;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_len(input int i);
    case (i)
      0: return 2;  1: return 100;  2: return 3;
      3: return 4;  4: return 0;    5: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, n);
    end
  endtask

  task automatic model_cycle();
    logic [7:0] prev_s;
    int d, k;
    prev_s = e_sample;
    if (rst_pending) begin
      rst_pending = 1'b0;
      active = 1'b0;
      e_sample = 8'h80; e_addr = '0; e_play = 1'b0; e_pc = '0; e_pwm = 1'b0;
    end else begin
      e_pwm = (e_pc < prev_s);
      e_pc  = e_pc + 8'd1;
      e_play = 1'b0;
      if (active) begin
        d = n - m_t;
        if (d == 1) begin
          e_addr = 14'(m_start);
          e_play = 1'b1;
        end else begin
          k = (d - 2) / DIV;
          if (k < m_len) begin
            e_sample = mem[(m_start + k) & 16383];
            e_addr   = 14'(m_start + k + 1);
            e_play   = 1'b1;
          end else begin
            e_sample = 8'h80;
            e_addr   = 14'(m_start + m_len);
            active   = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic step(input bit trig, input int sel, input bit rst);
    AUDIO_TRIGGER = trig;
    AUDIO_SELECT  = 4'(sel);
    RESET         = rst;
    if (rst) rst_pending = 1'b1;
    else if (trig && sel < 6 && ref_len(sel) > 0) begin
      active = 1'b1; m_t = n; m_start = ref_start(sel); m_len = ref_len(sel);
    end
    @(posedge CLK);
    n++;
    @(negedge CLK);
    AUDIO_TRIGGER = 1'b0;
    RESET = 1'b0;
    model_cycle();
    check_eq("rom_addr", 32'(ROM_ADDR), 32'(e_addr));
    check_eq("sample_out", 32'(SAMPLE_OUT), 32'(e_sample));
    check_eq("playing", 32'(PLAYING), 32'(e_play));
    check_eq("pwm_out", 32'(PWM_OUT), 32'(e_pwm));
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 0, 1'b0);
  endtask

  task automatic count_pwm(output int hi);
    hi = 0;
    repeat (256) begin
      step(1'b0, 0, 1'b0);
      hi += int'(PWM_OUT);
    end
  endtask

  initial begin
    int hi;
    for (int unsigned i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem['h100] = 8'h10; mem['h101] = 8'h20; mem['h102] = 8'h30;

    step(1'b0, 0, 1'b1);
    check_eq("reset_addr", 32'(ROM_ADDR), 32'h0);
    check_eq("reset_sample", 32'(SAMPLE_OUT), 32'h80);
    step(1'b0, 0, 1'b1);
    idle(3);

    // basic playback of sample 2
    step(1'b1, 2, 1'b0);
    check_eq("tp_addr_t1", 32'(ROM_ADDR), 32'h100);
    idle(1);  check_eq("tp_s0_t2", 32'(SAMPLE_OUT), 32'h10);
    idle(4);  check_eq("tp_s1_t6", 32'(SAMPLE_OUT), 32'h20);
    idle(4);  check_eq("tp_s2_t10", 32'(SAMPLE_OUT), 32'h30);
    idle(3);  check_eq("tp_play_t13", 32'(PLAYING), 32'h1);
    idle(1);  check_eq("tp_sil_t14", 32'(SAMPLE_OUT), 32'h80);
              check_eq("tp_stop_t14", 32'(PLAYING), 32'h0);
    idle(3);

    // retrigger at t+7 with sample 3
    step(1'b1, 2, 1'b0);
    idle(6);
    step(1'b1, 3, 1'b0);
    check_eq("retrig_addr", 32'(ROM_ADDR), 32'h200);
    idle(1);
    check_eq("retrig_s0", 32'(SAMPLE_OUT), 32'(mem['h200]));
    idle(20);

    // invalid index and zero-length triggers during playback are ignored
    step(1'b1, 2, 1'b0);
    idle(3);
    step(1'b1, 9, 1'b0);
    idle(2);
    step(1'b1, 4, 1'b0);
    idle(2);
    check_eq("inval_s2_t10", 32'(SAMPLE_OUT), 32'h30);
    idle(6);

    // reset mid-playback with a coincident trigger
    step(1'b1, 2, 1'b0);
    idle(4);
    step(1'b1, 3, 1'b1);
    check_eq("rst_sample", 32'(SAMPLE_OUT), 32'h80);
    check_eq("rst_playing", 32'(PLAYING), 32'h0);
    check_eq("rst_addr", 32'(ROM_ADDR), 32'h0);
    check_eq("rst_pwm", 32'(PWM_OUT), 32'h0);
    idle(10);

    // trigger coincident with a divider tick (t+5)
    step(1'b1, 5, 1'b0);
    idle(4);
    step(1'b1, 2, 1'b0);
    check_eq("tick_hold", 32'(SAMPLE_OUT), 32'(mem['h3F00]));
    idle(1);  check_eq("tick_s0", 32'(SAMPLE_OUT), 32'h10);
    idle(4);  check_eq("tick_s1", 32'(SAMPLE_OUT), 32'h20);
    idle(4);  check_eq("tick_s2", 32'(SAMPLE_OUT), 32'h30);
    idle(11);

    // PWM duty at silence and at a steady 0x40 level
    count_pwm(hi);
    check_eq("pwm_silence", 32'(hi), 32'd128);
    for (int unsigned i = 'h40; i < 'h40 + 100; i++) mem[i] = 8'h40;
    step(1'b1, 1, 1'b0);
    idle(2);
    count_pwm(hi);
    check_eq("pwm_0x40", 32'(hi), 32'd64);
    idle(150);

    // randomized triggers, bad indices and occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit trig, rst;
      trig = ($urandom_range(0, 99) < 3);
      rst  = ($urandom_range(0, 399) == 0);
      step(trig, int'($urandom_range(0, 15)), rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_sample_player.md
Name: audio_sample_player

Overview:
Consumer end of the game audio-trigger interface. It latches a sample index on a one-cycle trigger, looks up that sample's start address and length, and streams 8-bit unsigned samples from the synchronous sample ROM at a fixed sample rate. It drives a PWM audio pin and exposes the current sample level. It sits between the game controller's audio outputs and the board's audio pin / sample ROM.

Parameters:
SAMPLE_BITS, 4, width of AUDIO_SELECT; must equal sampleBits in the shared audio-sample include
ADDR_WIDTH, 14, sample ROM address width
CLK_DIV, 3125, clock cycles per audio sample (50 MHz / 16 kHz); legal range >= 2
SILENCE, 8'h80, idle output level (unsigned midpoint)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
AUDIO_SELECT  in  SAMPLE_BITS  sample index; sampled only in the cycle AUDIO_TRIGGER=1
AUDIO_TRIGGER  in  1  single-cycle start strobe
ROM_ADDR  out  ADDR_WIDTH  sample ROM address (registered)
ROM_DATA  in  8  ROM read data, valid one cycle after ROM_ADDR changes
SAMPLE_OUT  out  8  current sample level (registered)
PWM_OUT  out  1  PWM audio bit (registered)
PLAYING  out  1  high while a sample is being streamed

Behaviour:
- Reset values: ROM_ADDR=0, SAMPLE_OUT=SILENCE, PWM_OUT=0, PLAYING=0, FSM=IDLE, divider=0, PWM counter=0, remaining=0.
- Descriptor lookup: combinational function sampleStart(idx), sampleLength(idx) from the shared include; indices >= Sample_count are invalid.
- FSM states IDLE, PRIME, PLAY:
  - Any state, AUDIO_TRIGGER=1 with valid index and length>0 at cycle t: at t+1 ROM_ADDR=start, state=PRIME, PLAYING=1; previous playback is abandoned (retrigger preempts, latest trigger wins).
  - Trigger with invalid index or length 0: ignored entirely; current playback continues.
  - PRIME (one cycle): at t+2 state=PLAY, SAMPLE_OUT<=ROM_DATA (sample 0), ROM_ADDR<=start+1, remaining<=length-1, divider<=0.
  - PLAY: divider counts 0..CLK_DIV-1; tick when divider==CLK_DIV-1 (then wraps to 0). On tick with remaining>0: SAMPLE_OUT<=ROM_DATA, ROM_ADDR+1, remaining-1. On tick with remaining==0: SAMPLE_OUT<=SILENCE, PLAYING<=0, state=IDLE.
  - Timing: sample k visible from cycle t+2+k*CLK_DIV; silence from t+2+length*CLK_DIV.
- Trigger coincident with a tick: trigger has priority; tick is discarded.
- ROM_ADDR wraps modulo 2^ADDR_WIDTH; descriptors must not cross the wrap (checked by assertion, not by logic).
- PWM: free-running 8-bit counter incrementing every cycle; PWM_OUT <= (pwmCount < SAMPLE_OUT). SAMPLE_OUT=0 gives constant 0; 0xFF gives high 255/256 cycles.
- IDLE: ROM_ADDR holds its last value, SAMPLE_OUT=SILENCE.
- RESET mid-playback: next cycle all reset values apply; a trigger in the same cycle as RESET is ignored.

Decomposition:
- Shared include audio-samples.v: sampleBits, Sample_count, Sample_* indices, sampleStart/sampleLength functions (or localparam tables).
- Sample-rate divider: instance of the existing GenericCounter (COUNTER_MAX=CLK_DIV-1, TRIG_OUT as tick), RESET driven by RESET || trigger-accept || PRIME.
- PWM comparator kept inline; no further sub-modules.

Test Plan:
- CLK_DIV=4, sample 2 at start 0x100, length 3, ROM data 0x10,0x20,0x30: trigger at t -> ROM_ADDR=0x100 at t+1, SAMPLE_OUT=0x10 at t+2, 0x20 at t+6, 0x30 at t+10, SILENCE and PLAYING=0 at t+14.
- Retrigger: sample 2 playing, trigger sample 3 (start 0x200) at t+7 -> ROM_ADDR=0x200 at t+8, first sample of 3 at t+9, no further sample-2 data.
- Invalid index (>= Sample_count) or length-0 trigger during playback -> SAMPLE_OUT/ROM_ADDR sequence identical to the untriggered run.
- PWM: force SAMPLE_OUT=0x40 steady -> PWM_OUT high exactly 64 of every 256 cycles; SILENCE -> 128/256.
- RESET asserted at t+5 of a playback -> SAMPLE_OUT=0x80, PLAYING=0, ROM_ADDR=0, PWM_OUT=0 at t+6; a trigger in the reset cycle has no effect.
- Trigger coincident with a tick -> new sample restarts at trigger+2 with no sample skipped or duplicated in the new stream.
